// File: rtl/vram_blit_ctrl.sv
// rtl/vram_blit_ctrl.sv - VRAM clear/scroll engine muxed onto the CPU VRAM port.
// Optional irq/irq_ack interrupt logic is enabled by defining VRAM_BLIT_IRQ_EN.
module vram_blit_ctrl #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 16
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        fill_data,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] cpu_abus,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_we,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] vram_abus,
  output logic [7:0]        vram_wdata,
  output logic              vram_we,
  input  logic [7:0]        vram_rdata
`ifdef VRAM_BLIT_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_ack
`endif
);

  localparam logic [ADDR_W-1:0] L_ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] L_COLS      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] L_LAST      = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] L_COPY_LAST = ADDR_W'(COLS * (ROWS - 1) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SC_RD,
    S_SC_WR,
    S_SC_FILL,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;
  logic [7:0]        r_fill;
  logic              w_accept;
  logic [ADDR_W-1:0] w_dst;
  logic [ADDR_W-1:0] w_abus;
  logic [7:0]        w_wdata;
  logic              w_we;
  logic              w_busy;
  logic              w_done;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_fill  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      if (w_accept) begin
        r_fill <= fill_data;
      end
    end
  end

  // During a scroll r_ptr is the source address; the destination trails it by one row,
  // and the bottom-row fill continues from the same pointer once it reaches the end.
  assign w_dst = r_ptr - L_COLS;

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_accept     = 1'b0;
    w_abus       = cpu_abus;
    w_wdata      = cpu_wdata;
    w_we         = cpu_we;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && (cmd_op == 2'b01 || cmd_op == 2'b10)) begin
          w_accept = 1'b1;
          if (cmd_op == 2'b01) begin
            w_state_next = S_CLR;
            w_ptr_next   = '0;
          end else begin
            w_state_next = S_SC_RD;
            w_ptr_next   = L_COLS;
          end
        end
      end
      S_CLR: begin
        w_busy  = 1'b1;
        w_abus  = r_ptr;
        w_wdata = r_fill;
        w_we    = 1'b1;
        if (r_ptr == L_LAST) begin
          w_state_next = S_FIN;
          w_ptr_next   = '0;
        end else begin
          w_ptr_next = r_ptr + L_ONE;
        end
      end
      S_SC_RD: begin
        w_busy       = 1'b1;
        w_abus       = r_ptr;
        w_wdata      = r_fill;
        w_we         = 1'b0;
        w_state_next = S_SC_WR;
      end
      S_SC_WR: begin
        w_busy     = 1'b1;
        w_abus     = w_dst;
        w_wdata    = vram_rdata;
        w_we       = 1'b1;
        w_ptr_next = r_ptr + L_ONE;
        if (w_dst == L_COPY_LAST) begin
          w_state_next = S_SC_FILL;
        end else begin
          w_state_next = S_SC_RD;
        end
      end
      S_SC_FILL: begin
        w_busy  = 1'b1;
        w_abus  = w_dst;
        w_wdata = r_fill;
        w_we    = 1'b1;
        if (w_dst == L_LAST) begin
          w_state_next = S_FIN;
          w_ptr_next   = '0;
        end else begin
          w_ptr_next = r_ptr + L_ONE;
        end
      end
      S_FIN: begin
        w_done       = 1'b1;
        w_abus       = '0;
        w_wdata      = r_fill;
        w_we         = 1'b0;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_ptr_next   = '0;
      end
    endcase
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = w_busy;
  assign done       = w_done;
  assign cpu_wait   = w_busy;
  assign cpu_rdata  = vram_rdata;
  assign vram_abus  = w_abus;
  assign vram_wdata = w_wdata;
  assign vram_we    = w_we;

`ifdef VRAM_BLIT_IRQ_EN
  logic r_irq;

  // A completion in the same cycle as an acknowledge must not be lost.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else if (w_done) begin
      r_irq <= 1'b1;
    end else if (irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule
